// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family:
// operation encodings and the segment-geometry check.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when the operand width splits into equal, non-empty segments.
  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// Combinational N-bit ripple-carry segment built from fa cells; also exposes
// the carry into its top bit so the final segment can derive signed overflow.
module rca_seg #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [N:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    fa u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  assign co       = c[N];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, carry
// registered between stages, global stall when the result is not taken.
module rca_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $fatal(1, "rca_pipe: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign c0       = (sub == OP_SUB) ? 1'b1 : ci;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits still unconsumed on entry, and result bits known on exit.
    localparam int REM  = WIDTH - gi * SEG;
    localparam int DONE = (gi + 1) * SEG;

    logic [REM-1:0]  a_rem;
    logic [REM-1:0]  b_rem;
    logic            c_in;
    logic            v_in;
    logic [SEG-1:0]  s_seg;
    logic            c_out;
    logic [DONE-1:0] sum_next;
    logic [DONE-1:0] sum_reg;
    logic            c_reg;
    logic            v_reg;

    if (gi == 0) begin : g_first
      assign a_rem    = a;
      assign b_rem    = b_eff;
      assign c_in     = c0;
      assign v_in     = in_valid;
      assign sum_next = s_seg;
    end else begin : g_next
      assign a_rem    = g_stage[gi-1].g_skew.a_reg;
      assign b_rem    = g_stage[gi-1].g_skew.b_reg;
      assign c_in     = g_stage[gi-1].c_reg;
      assign v_in     = g_stage[gi-1].v_reg;
      assign sum_next = {s_seg, g_stage[gi-1].sum_reg};
    end

    if (gi == STAGES - 1) begin : g_last
      logic c_msb;
      logic ovf_reg;

      rca_seg #(.N(SEG)) u_seg (
        .a        (a_rem[SEG-1:0]),
        .b        (b_rem[SEG-1:0]),
        .ci       (c_in),
        .s        (s_seg),
        .co       (c_out),
        .c_msb_in (c_msb)
      );

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= c_msb ^ c_out;
        end
      end
    end else begin : g_mid
      logic c_msb_unused;

      rca_seg #(.N(SEG)) u_seg (
        .a        (a_rem[SEG-1:0]),
        .b        (b_rem[SEG-1:0]),
        .ci       (c_in),
        .s        (s_seg),
        .co       (c_out),
        .c_msb_in (c_msb_unused)
      );
    end

    // Upper operand slices ride alongside until their stage is reached.
    if (gi < STAGES - 1) begin : g_skew
      logic [REM-SEG-1:0] a_reg;
      logic [REM-SEG-1:0] b_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_rem[REM-1:SEG];
          b_reg <= b_rem[REM-1:SEG];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sum_reg <= '0;
        c_reg   <= 1'b0;
        v_reg   <= 1'b0;
      end else if (adv) begin
        sum_reg <= sum_next;
        c_reg   <= c_out;
        v_reg   <= v_in;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_reg;
  assign s         = g_stage[STAGES-1].sum_reg;
  assign co        = g_stage[STAGES-1].c_reg;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: an 8-bit/2-stage instance for directed, stall and reset
// cases, plus 32-bit instances with 1, 4 and 8 stages for a latency-checked sweep.
module tb_rca_pipe;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  logic end_chk  = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: wide integer add, overflow from operand/result sign rule.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    exp_t        r;
    logic [32:0] mask;
    logic [32:0] bb;
    logic [32:0] sum;
    mask  = (33'd1 << w) - 33'd1;
    bb    = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    sum   = ({1'b0, a} & mask) + bb + (sub ? 33'd1 : {32'd0, ci});
    r.s   = sum[31:0] & mask[31:0];
    r.co  = sum[w];
    r.ovf = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
    r.t   = 0;
    return r;
  endfunction

  // 8-bit, 2-stage instance
  logic [7:0] a8, b8, s8;
  logic       ci8, sub8, iv8, ir8, or8, ov8, co8, ovf8;

  rca_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .ci        (ci8),
    .sub       (sub8),
    .out_valid (ov8),
    .out_ready (or8),
    .s         (s8),
    .co        (co8),
    .ovf       (ovf8)
  );

  exp_t q8[$];
  exp_t e8;

  always @(negedge clk) begin
    if (!reset_n) begin
      q8.delete();
    end else begin
      if (ov8 && or8) begin
        chk("w8_out_expected", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk("w8_s", 64'(s8), 64'(e8.s));
          chk("w8_co", 64'(co8), 64'(e8.co));
          chk("w8_ovf", 64'(ovf8), 64'(e8.ovf));
        end
      end
      if (iv8 && ir8) begin
        e8 = model(8, {24'd0, a8}, {24'd0, b8}, ci8, sub8);
        q8.push_back(e8);
      end
    end
  end

  // 32-bit instances sharing one stimulus stream; out_ready held high
  logic [31:0] a32, b32;
  logic        ci32, sub32, iv32, or32;

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);

    logic        ir_o, ov_o, co_o, ovf_o;
    logic [31:0] s_o;
    exp_t        q[$];
    exp_t        e;

    rca_pipe #(.WIDTH(32), .STAGES(ST)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (iv32),
      .in_ready  (ir_o),
      .a         (a32),
      .b         (b32),
      .ci        (ci32),
      .sub       (sub32),
      .out_valid (ov_o),
      .out_ready (or32),
      .s         (s_o),
      .co        (co_o),
      .ovf       (ovf_o)
    );

    always @(negedge clk) begin
      if (!reset_n) begin
        q.delete();
      end else begin
        if (ov_o && or32) begin
          chk($sformatf("w32_st%0d_out_expected", ST), 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("w32_st%0d_s", ST), 64'(s_o), 64'(e.s));
            chk($sformatf("w32_st%0d_co", ST), 64'(co_o), 64'(e.co));
            chk($sformatf("w32_st%0d_ovf", ST), 64'(ovf_o), 64'(e.ovf));
            chk($sformatf("w32_st%0d_latency", ST), 64'(edge_cnt - e.t), 64'(ST));
          end
        end
        if (iv32 && ir_o) begin
          e   = model(32, a32, b32, ci32, sub32);
          e.t = edge_cnt;
          q.push_back(e);
        end
      end
    end

    initial begin
      wait (end_chk);
      chk($sformatf("w32_st%0d_drained", ST), 64'(q.size()), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a_v, input logic [7:0] b_v, input logic ci_v,
                        input logic sub_v);
    a8   = a_v;
    b8   = b_v;
    ci8  = ci_v;
    sub8 = sub_v;
    iv8  = 1'b1;
  endtask

  task automatic drive32(input logic [31:0] a_v, input logic [31:0] b_v, input logic ci_v,
                         input logic sub_v);
    a32   = a_v;
    b32   = b_v;
    ci32  = ci_v;
    sub32 = sub_v;
    iv32  = 1'b1;
  endtask

  int         sent;
  int         cyc;
  logic       acc;
  logic [7:0] s_hold;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("w8_rst_out_valid", 64'(ov8), 64'd0);
    chk("w8_rst_s", 64'(s8), 64'd0);
    chk("w8_rst_co", 64'(co8), 64'd0);
    chk("w8_rst_ovf", 64'(ovf8), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("w8_in_ready_after_reset", 64'(ir8), 64'd1);

    // 0x3C + 0x15 + 1, two-cycle latency, single-cycle valid
    drive8(8'h3C, 8'h15, 1'b1, 1'b0);
    tick();
    iv8 = 1'b0;
    chk("w8_t1_not_early", 64'(ov8), 64'd0);
    tick();
    chk("w8_t1_valid", 64'(ov8), 64'd1);
    chk("w8_t1_s", 64'(s8), 64'h52);
    chk("w8_t1_co", 64'(co8), 64'd0);
    chk("w8_t1_ovf", 64'(ovf8), 64'd0);
    tick();
    chk("w8_t1_one_cycle", 64'(ov8), 64'd0);

    // Signed overflow then subtraction, back to back
    drive8(8'h7F, 8'h01, 1'b0, 1'b0);
    tick();
    drive8(8'h05, 8'h07, 1'b1, 1'b1);
    tick();
    iv8 = 1'b0;
    chk("w8_t2a_valid", 64'(ov8), 64'd1);
    chk("w8_t2a_s", 64'(s8), 64'h80);
    chk("w8_t2a_co", 64'(co8), 64'd0);
    chk("w8_t2a_ovf", 64'(ovf8), 64'd1);
    tick();
    chk("w8_t2b_valid", 64'(ov8), 64'd1);
    chk("w8_t2b_s", 64'(s8), 64'hFE);
    chk("w8_t2b_co", 64'(co8), 64'd0);
    chk("w8_t2b_ovf", 64'(ovf8), 64'd0);
    tick();
    chk("w8_t2_idle", 64'(ov8), 64'd0);

    // Carry across the stage boundary
    drive8(8'hFF, 8'h01, 1'b1, 1'b0);
    tick();
    iv8 = 1'b0;
    tick();
    chk("w8_t3_valid", 64'(ov8), 64'd1);
    chk("w8_t3_s", 64'(s8), 64'h01);
    chk("w8_t3_co", 64'(co8), 64'd1);
    tick();

    // Ten random operations with a three-cycle output stall mid-stream
    sent   = 0;
    cyc    = 0;
    s_hold = '0;
    drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (sent < 10 && cyc < 200) begin
      or8 = !(cyc >= 5 && cyc < 8);
      #1;
      if (cyc == 5) begin
        s_hold = s8;
        chk("w8_stall_out_valid", 64'(ov8), 64'd1);
      end
      if (!or8) chk("w8_stall_in_ready", 64'(ir8), 64'd0);
      if (!or8 && cyc > 5) chk("w8_stall_s_frozen", 64'(s8), 64'(s_hold));
      acc = ir8;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 10)
          drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        else
          iv8 = 1'b0;
      end
    end
    chk("w8_stream_sent", 64'(sent), 64'd10);
    iv8 = 1'b0;
    or8 = 1'b1;
    repeat (4) tick();
    chk("w8_stream_drained", 64'(q8.size()), 64'd0);

    // Two operations in flight (held by a stall), then reset
    or8 = 1'b0;
    drive8(8'hFF, 8'h80, 1'b0, 1'b0);
    tick();
    drive8(8'h33, 8'h44, 1'b0, 1'b0);
    tick();
    iv8 = 1'b0;
    chk("w8_inflight_valid", 64'(ov8), 64'd1);
    reset_n = 1'b0;
    tick();
    chk("w8_midrst_out_valid", 64'(ov8), 64'd0);
    chk("w8_midrst_s", 64'(s8), 64'd0);
    chk("w8_midrst_co", 64'(co8), 64'd0);
    chk("w8_midrst_ovf", 64'(ovf8), 64'd0);
    reset_n = 1'b1;
    or8 = 1'b1;
    repeat (4) begin
      tick();
      chk("w8_no_stale", 64'(ov8), 64'd0);
    end

    // 32-bit edge cases and random sweep across STAGES = 1, 4, 8
    drive32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    tick();
    drive32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    tick();
    drive32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
    tick();
    drive32(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    tick();
    repeat (40) begin
      drive32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      iv32 = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv32 = 1'b0;
    repeat (12) tick();

    end_chk = 1'b1;
    #1;
    chk("w8_final_drained", 64'(q8.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
